// File: rtl/ipd_stage_pkg.sv
// Shared definitions for the instruction pre-decode stage: bus widths,
// LoongArch branch opcodes and the pre-decode flag bundle.
package ipd_stage_pkg;

    localparam int IF_TO_IPD_BUS_WD = 64;
    localparam int IPD_TO_ID_BUS_WD = 132;

    localparam logic [5:0] OPC_B    = 6'b010100;
    localparam logic [5:0] OPC_BL   = 6'b010101;
    localparam logic [5:0] OPC_JIRL = 6'b010011;
    localparam logic [5:0] OPC_BEQ  = 6'b010110;
    localparam logic [5:0] OPC_BNE  = 6'b010111;
    localparam logic [5:0] OPC_BLT  = 6'b011000;
    localparam logic [5:0] OPC_BGE  = 6'b011001;
    localparam logic [5:0] OPC_BLTU = 6'b011010;
    localparam logic [5:0] OPC_BGEU = 6'b011011;

    // Bit order matches the top nibble of the IPD->ID bus.
    typedef struct packed {
        logic is_cond_br;
        logic is_b;
        logic is_bl;
        logic is_jirl;
    } br_flags_t;

endpackage

// File: rtl/ipd_stage_if.sv
// Generic valid/allow_in handshake carrying a payload bus. The producer
// uses the master modport, the consumer the slave modport.
interface ipd_stage_if
    import ipd_stage_pkg::*;
#(
    parameter int WIDTH = IF_TO_IPD_BUS_WD
);

    logic [WIDTH-1:0] bus;
    logic             valid;
    logic             allow_in;

    modport master (output bus, output valid, input allow_in);
    modport slave  (input bus, input valid, output allow_in);

endinterface

// File: rtl/ipd_predecode.sv
// Combinational LoongArch branch pre-decoder: classifies the instruction
// and computes the direct branch target. Kept standalone so ID can reuse it.
module ipd_predecode
    import ipd_stage_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] inst_PC,
    output br_flags_t   flags,
    output logic [31:0] br_target
);

    logic [5:0]  opc;
    logic [31:0] offs16;
    logic [31:0] offs26;

    assign opc    = inst[31:26];
    assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b00};
    assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

    // Classify by opcode; jirl and non-branches carry a zero target.
    always_comb begin
        flags     = '0;
        br_target = '0;
        case (opc)
            OPC_B: begin
                flags.is_b = 1'b1;
                br_target  = inst_PC + offs26;
            end
            OPC_BL: begin
                flags.is_bl = 1'b1;
                br_target   = inst_PC + offs26;
            end
            OPC_JIRL: begin
                flags.is_jirl = 1'b1;
            end
            OPC_BEQ, OPC_BNE, OPC_BLT, OPC_BGE, OPC_BLTU, OPC_BGEU: begin
                flags.is_cond_br = 1'b1;
                br_target        = inst_PC + offs16;
            end
            default: begin
                flags     = '0;
                br_target = '0;
            end
        endcase
    end

endmodule

// File: rtl/ipd_stage.sv
// Instruction pre-decode stage. Captures IF's instruction and PCs into a
// 2-entry FIFO together with the pre-decoded branch info, and presents the
// head entry to ID. A misprediction from ID empties the FIFO.
module ipd_stage
    import ipd_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    ipd_stage_if.slave         if_in,
    input  logic [31:0]        inst_ram_r_data,
    input  logic               br_taken_cancel,
    ipd_stage_if.master        id_out
);

    logic [IPD_TO_ID_BUS_WD-1:0] entry_q [2];
    logic                        rd_ptr;
    logic                        wr_ptr;
    logic [1:0]                  count;

    br_flags_t                   pd_flags;
    logic [31:0]                 pd_target;
    logic [IPD_TO_ID_BUS_WD-1:0] new_entry;
    logic                        push;
    logic                        pop;

    ipd_predecode u_predecode (
        .inst      (inst_ram_r_data),
        .inst_PC   (if_in.bus[31:0]),
        .flags     (pd_flags),
        .br_target (pd_target)
    );

    assign new_entry = {pd_flags, pd_target, if_in.bus[63:32], if_in.bus[31:0], inst_ram_r_data};

    // allow_in comes only from the registered count, so ID's stall never
    // reaches back to IF combinationally; a full FIFO refuses even if ID pops.
    assign if_in.allow_in = (count != 2'd2);
    assign id_out.valid   = (count != 2'd0) & ~br_taken_cancel;
    assign id_out.bus     = (count == 2'd0) ? '0 : entry_q[rd_ptr];

    assign push = if_in.valid & if_in.allow_in & ~br_taken_cancel;
    assign pop  = id_out.valid & id_out.allow_in;

    // Payload storage; left uncleared on reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wr_ptr] <= new_entry;
        end
    end

    // Pointer and occupancy bookkeeping; reset, then flush, take priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (br_taken_cancel) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ipd_stage.sv
// Directed testbench for ipd_stage: pre-decode results, ID stall,
// flush, streaming across pointer wrap, and reset mid-stream.
module tb_ipd_stage;
    import ipd_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_ram_r_data;
    logic        br_taken_cancel;

    ipd_stage_if #(.WIDTH(IF_TO_IPD_BUS_WD)) if_bus ();
    ipd_stage_if #(.WIDTH(IPD_TO_ID_BUS_WD)) id_bus ();

    int tests_run    = 0;
    int tests_failed = 0;

    ipd_stage dut (
        .clk             (clk),
        .reset           (reset),
        .if_in           (if_bus),
        .inst_ram_r_data (inst_ram_r_data),
        .br_taken_cancel (br_taken_cancel),
        .id_out          (id_bus)
    );

    // Free-running 10 ns clock; inputs change on the falling edge.
    always #5 clk = ~clk;

    // Expected head entry built from hand-computed flags and target.
    function automatic logic [131:0] make_entry(input logic [3:0] f, input logic [31:0] tgt,
                                                input logic [31:0] pc, input logic [31:0] inst);
        return {f, tgt, pc + 32'd4, pc, inst};
    endfunction

    task automatic applyStimulus(input logic vld, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic id_allow, input logic cancel, input logic rst);
        if_bus.valid    = vld;
        if_bus.bus      = {pc + 32'd4, pc};
        inst_ram_r_data = inst;
        id_bus.allow_in = id_allow;
        br_taken_cancel = cancel;
        reset           = rst;
    endtask

    task automatic test_reset();
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c000000, 32'h50000400, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++; if (id_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", id_bus.valid); end
        tests_run++; if (if_bus.allow_in !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_allow_in: got %b expected 1", if_bus.allow_in); end
        tests_run++; if (id_bus.bus !== 132'd0) begin tests_failed++; $display("[TB] FAIL reset_bus: got %h expected 0", id_bus.bus); end
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_predecode();
        logic [31:0]  pcs   [9];
        logic [31:0]  insts [9];
        logic [3:0]   flg   [9];
        logic [31:0]  tgts  [9];
        logic [131:0] exp_e;
        pcs   = '{32'h1c000000, 32'h1c000010, 32'h1c000020, 32'h00000000, 32'h1c000030,
                  32'h1c000040, 32'h1c000050, 32'h1c000060, 32'h1c000070};
        insts = '{32'h50000400, 32'h57FFFFFF, 32'h58000800, 32'h6FFFFC00, 32'h4C000001,
                  32'h70000000, 32'h48000000, 32'h5C000C00, 32'h50000200};
        flg   = '{4'b0100, 4'b0010, 4'b1000, 4'b1000, 4'b0001,
                  4'b0000, 4'b0000, 4'b1000, 4'b0100};
        tgts  = '{32'h1c000004, 32'h1c00000c, 32'h1c000028, 32'hfffffffc, 32'h00000000,
                  32'h00000000, 32'h00000000, 32'h1c00006c, 32'h14000070};
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i < 9) applyStimulus(1'b1, pcs[i], insts[i], 1'b1, 1'b0, 1'b0);
            else       applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            #1;
            if (i == 0) begin
                tests_run++; if (id_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL pd_first_latency: got valid %b expected 0", id_bus.valid); end
            end else begin
                exp_e = make_entry(flg[i-1], tgts[i-1], pcs[i-1], insts[i-1]);
                tests_run++; if (id_bus.valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL pd_valid[%0d]: got %b expected 1", i-1, id_bus.valid); end
                tests_run++; if (id_bus.bus[131:128] !== flg[i-1]) begin tests_failed++; $display("[TB] FAIL pd_flags[%0d]: got %b expected %b", i-1, id_bus.bus[131:128], flg[i-1]); end
                tests_run++; if (id_bus.bus[127:96] !== tgts[i-1]) begin tests_failed++; $display("[TB] FAIL pd_target[%0d]: got %h expected %h", i-1, id_bus.bus[127:96], tgts[i-1]); end
                tests_run++; if (id_bus.bus !== exp_e) begin tests_failed++; $display("[TB] FAIL pd_bus[%0d]: got %h expected %h", i-1, id_bus.bus, exp_e); end
            end
        end
        @(negedge clk);
        #1;
        tests_run++; if (id_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL pd_drain: got valid %b expected 0", id_bus.valid); end
    endtask

    task automatic test_stall();
        logic [131:0] ea;
        logic [131:0] eb;
        ea = make_entry(4'b0000, 32'h0, 32'h1c000100, 32'h02800001);
        eb = make_entry(4'b0000, 32'h0, 32'h1c000104, 32'h02800002);
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c000100, 32'h02800001, 1'b0, 1'b0, 1'b0);
        #1;
        tests_run++; if (if_bus.allow_in !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_allow_c0: got %b expected 1", if_bus.allow_in); end
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c000104, 32'h02800002, 1'b0, 1'b0, 1'b0);
        #1;
        tests_run++; if (if_bus.allow_in !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_allow_c1: got %b expected 1", if_bus.allow_in); end
        tests_run++; if (id_bus.bus !== ea) begin tests_failed++; $display("[TB] FAIL stall_head_c1: got %h expected %h", id_bus.bus, ea); end
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c000108, 32'h02800003, 1'b0, 1'b0, 1'b0);
        #1;
        tests_run++; if (if_bus.allow_in !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_allow_full: got %b expected 0", if_bus.allow_in); end
        tests_run++; if (id_bus.valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_valid_full: got %b expected 1", id_bus.valid); end
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        tests_run++; if (if_bus.allow_in !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_allow_pop_cycle: got %b expected 0", if_bus.allow_in); end
        tests_run++; if (id_bus.bus !== ea) begin tests_failed++; $display("[TB] FAIL stall_pop_first: got %h expected %h", id_bus.bus, ea); end
        @(negedge clk);
        #1;
        tests_run++; if (if_bus.allow_in !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_allow_after_pop: got %b expected 1", if_bus.allow_in); end
        tests_run++; if (id_bus.valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_valid_second: got %b expected 1", id_bus.valid); end
        tests_run++; if (id_bus.bus !== eb) begin tests_failed++; $display("[TB] FAIL stall_pop_second: got %h expected %h", id_bus.bus, eb); end
        @(negedge clk);
        #1;
        tests_run++; if (id_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_third_dropped: got valid %b expected 0", id_bus.valid); end
    endtask

    task automatic test_flush();
        logic [131:0] eg;
        eg = make_entry(4'b0100, 32'h1c000204, 32'h1c000200, 32'h50000400);
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c000180, 32'h02800011, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c000184, 32'h02800012, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c000188, 32'h02800013, 1'b1, 1'b1, 1'b0);
        #1;
        tests_run++; if (id_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_valid_cancel_cycle: got %b expected 0", id_bus.valid); end
        tests_run++; if (if_bus.allow_in !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_allow_cancel_cycle: got %b expected 0", if_bus.allow_in); end
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        tests_run++; if (id_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_valid_after: got %b expected 0", id_bus.valid); end
        tests_run++; if (if_bus.allow_in !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_allow_after: got %b expected 1", if_bus.allow_in); end
        tests_run++; if (id_bus.bus !== 132'd0) begin tests_failed++; $display("[TB] FAIL flush_bus_after: got %h expected 0", id_bus.bus); end
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c000200, 32'h50000400, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        tests_run++; if (id_bus.valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_refill_valid: got %b expected 1", id_bus.valid); end
        tests_run++; if (id_bus.bus !== eg) begin tests_failed++; $display("[TB] FAIL flush_refill_bus: got %h expected %h", id_bus.bus, eg); end
        @(negedge clk);
        #1;
        tests_run++; if (id_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_refill_drain: got %b expected 0", id_bus.valid); end
    endtask

    task automatic test_stream();
        logic [131:0] exp_e;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) applyStimulus(1'b1, 32'h1c001000 + 32'(4 * i), 32'h02800000 + 32'(i), 1'b1, 1'b0, 1'b0);
            else       applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            #1;
            tests_run++; if (if_bus.allow_in !== 1'b1) begin tests_failed++; $display("[TB] FAIL stream_allow[%0d]: got %b expected 1", i, if_bus.allow_in); end
            if (i > 0) begin
                exp_e = make_entry(4'b0000, 32'h0, 32'h1c001000 + 32'(4 * (i - 1)), 32'h02800000 + 32'(i - 1));
                tests_run++; if (id_bus.valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", i-1, id_bus.valid); end
                tests_run++; if (id_bus.bus !== exp_e) begin tests_failed++; $display("[TB] FAIL stream_bus[%0d]: got %h expected %h", i-1, id_bus.bus, exp_e); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [131:0] ey;
        ey = make_entry(4'b0000, 32'h0, 32'h1c002004, 32'h02800022);
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c002000, 32'h02800021, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c002004, 32'h02800022, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h1c002008, 32'h02800023, 1'b1, 1'b0, 1'b1);
        #1;
        tests_run++; if (id_bus.bus !== ey) begin tests_failed++; $display("[TB] FAIL rst_mid_head: got %h expected %h", id_bus.bus, ey); end
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        tests_run++; if (id_bus.valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", id_bus.valid); end
        tests_run++; if (if_bus.allow_in !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_allow: got %b expected 1", if_bus.allow_in); end
        tests_run++; if (id_bus.bus !== 132'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_bus: got %h expected 0", id_bus.bus); end
    endtask

    initial begin
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_predecode();
        test_stall();
        test_flush();
        test_stream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
